ppu_timing_gen: RTL and testbench

- Parametrised scanline/frame timing generator for the GameMan PPU. It replaces fixed-constant mode sequencing with configurable line length, visible/vblank line counts and mode-3 length bounds.
- Drives the mode-2 (OAM search) and mode-3 (pixel fetch) engines through start/done handshakes.
- Maintains LY and the LYC compare, and produces edge-detected STAT and VBLANK interrupt pulses.
- Sits between the LCDC/STAT register file and the mode FSMs.

---
 rtl/ppu_pkg.sv | 30 +++
 rtl/ppu_stat_irq.sv | 46 ++++
 rtl/ppu_timing_gen.sv | 195 +++++++++++++++++++
 tb/tb_ppu_timing_gen.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// Shared PPU timing types, STAT mode encodings and default scanline/frame constants.
package ppu_pkg;

  typedef enum logic [2:0] {OFF, M2, M3, M0, M1} ppu_mode_t;

  localparam logic [1:0] MODE_HBLANK = 2'd0;
  localparam logic [1:0] MODE_VBLANK = 2'd1;
  localparam logic [1:0] MODE_OAM    = 2'd2;
  localparam logic [1:0] MODE_XFER   = 2'd3;

  localparam int unsigned DEF_LINE_CYCLES   = 456;
  localparam int unsigned DEF_VISIBLE_LINES = 144;
  localparam int unsigned DEF_VBLANK_LINES  = 10;
  localparam int unsigned DEF_OAM_CYCLES    = 80;
  localparam int unsigned DEF_MIN_M3_CYCLES = 172;
  localparam int unsigned DEF_MAX_M3_CYCLES = 289;

  // OFF reports mode 0 so STAT[1:0] reads as H-blank while the LCD is disabled.
  function automatic logic [1:0] mode_enc(input ppu_mode_t st);
    logic [1:0] m;
    case (st)
      M1:      m = MODE_VBLANK;
      M2:      m = MODE_OAM;
      M3:      m = MODE_XFER;
      default: m = MODE_HBLANK;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ppu_stat_irq.sv
// LYC compare, STAT line combine and rising-edge detect for the STAT interrupt.
module ppu_stat_irq
  import ppu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       run_i,
  input  logic       active_i,
  input  logic [7:0] ly_next_i,
  input  logic [7:0] lyc_i,
  input  logic [3:0] stat_src_en_i,
  input  logic [1:0] mode_i,
  output logic       lyc_eq_o,
  output logic       stat_irq_o
);

  logic lyc_eq_q, lyc_eq_d;
  logic stat_line, stat_line_q;
  logic stat_irq_q, stat_irq_d;

  // lyc_eq tracks the line being entered so it moves on the same edge as ly.
  always_comb begin
    lyc_eq_d   = run_i && (ly_next_i == lyc_i);
    stat_line  = active_i && ((lyc_eq_q && stat_src_en_i[3]) ||
                              ((mode_i == MODE_OAM) && stat_src_en_i[2]) ||
                              ((mode_i == MODE_VBLANK) && stat_src_en_i[1]) ||
                              ((mode_i == MODE_HBLANK) && stat_src_en_i[0]));
    stat_irq_d = run_i && stat_line && !stat_line_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lyc_eq_q    <= 1'b0;
      stat_line_q <= 1'b0;
      stat_irq_q  <= 1'b0;
    end else begin
      lyc_eq_q    <= lyc_eq_d;
      stat_line_q <= stat_line;
      stat_irq_q  <= stat_irq_d;
    end
  end

  assign lyc_eq_o   = lyc_eq_q;
  assign stat_irq_o = stat_irq_q;

endmodule

// File: rtl/ppu_timing_gen.sv
// Scanline/frame timing generator sequencing PPU modes 2/3/0/1, LY and interrupts.
// Define PPU_M3_TIMEOUT_EN to force mode 0 when mode 3 reaches MAX_M3_CYCLES.
module ppu_timing_gen
  import ppu_pkg::*;
#(
  parameter int unsigned LINE_CYCLES   = DEF_LINE_CYCLES,
  parameter int unsigned VISIBLE_LINES = DEF_VISIBLE_LINES,
  parameter int unsigned VBLANK_LINES  = DEF_VBLANK_LINES,
  parameter int unsigned OAM_CYCLES    = DEF_OAM_CYCLES,
  parameter int unsigned MIN_M3_CYCLES = DEF_MIN_M3_CYCLES,
  parameter int unsigned MAX_M3_CYCLES = DEF_MAX_M3_CYCLES,
  parameter int unsigned DOT_W         = $clog2(LINE_CYCLES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lcd_en_i,
  input  logic [7:0]       lyc_i,
  input  logic [3:0]       stat_src_en_i,
  input  logic             m3_done_i,
  output logic             m2_start_o,
  output logic             m3_start_o,
  output logic [1:0]       mode_o,
  output logic [7:0]       ly_o,
  output logic [DOT_W-1:0] dot_o,
  output logic             lyc_eq_o,
  output logic             stat_irq_o,
  output logic             vblank_irq_o,
  output logic             frame_start_o,
  output logic             m3_overrun_o
);

  localparam int unsigned TOTAL_LINES = VISIBLE_LINES + VBLANK_LINES;

  localparam logic [DOT_W-1:0] LastDot    = DOT_W'(LINE_CYCLES - 1);
  localparam logic [DOT_W-1:0] OamLastDot = DOT_W'(OAM_CYCLES - 1);
  // Last M3 dot before which an accepted m3_done must still be held off.
  localparam logic [DOT_W-1:0] M3MinDot   = DOT_W'(OAM_CYCLES + MIN_M3_CYCLES - 1);
  localparam logic [7:0]       LastVisLy  = 8'(VISIBLE_LINES - 1);
  localparam logic [7:0]       LastLy     = 8'(TOTAL_LINES - 1);

`ifdef PPU_M3_TIMEOUT_EN
  localparam logic [DOT_W-1:0] M3TmoDot   = DOT_W'(OAM_CYCLES + MAX_M3_CYCLES - 1);
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^DOT_W'(MAX_M3_CYCLES);
`endif

  ppu_mode_t        state_q, state_d;
  logic [DOT_W-1:0] dot_q, dot_d;
  logic [7:0]       ly_q, ly_d;
  logic [1:0]       mode_q, mode_d;
  logic             m2_start_q, m2_start_d;
  logic             m3_start_q, m3_start_d;
  logic             vblank_irq_q, vblank_irq_d;
  logic             frame_start_q, frame_start_d;
  logic             overrun_q, overrun_d;
  logic             done_lat_q, done_lat_d;
  logic             line_end, done_seen, next_line;
  logic             run_d, active_q;

  always_comb begin
    state_d       = state_q;
    dot_d         = dot_q + 1'b1;
    ly_d          = ly_q;
    m2_start_d    = 1'b0;
    m3_start_d    = 1'b0;
    vblank_irq_d  = 1'b0;
    frame_start_d = 1'b0;
    overrun_d     = overrun_q;
    done_lat_d    = 1'b0;
    next_line     = 1'b0;
    line_end      = (dot_q == LastDot);
    done_seen     = m3_done_i || done_lat_q;

    if (!lcd_en_i) begin
      state_d   = OFF;
      dot_d     = '0;
      ly_d      = '0;
      overrun_d = 1'b0;
    end else begin
      unique case (state_q)
        OFF: begin
          state_d       = M2;
          dot_d         = '0;
          ly_d          = '0;
          m2_start_d    = 1'b1;
          frame_start_d = 1'b1;
        end
        M2: begin
          if (dot_q == OamLastDot) begin
            state_d    = M3;
            m3_start_d = 1'b1;
          end
        end
        M3: begin
          // Line end takes precedence; a done on that same dot still counts as in time.
          if (line_end) begin
            next_line = 1'b1;
            if (!done_seen) overrun_d = 1'b1;
          end else if (done_seen && (dot_q >= M3MinDot)) begin
            state_d = M0;
`ifdef PPU_M3_TIMEOUT_EN
          end else if (dot_q >= M3TmoDot) begin
            state_d   = M0;
            overrun_d = 1'b1;
`endif
          end else begin
            done_lat_d = done_seen;
          end
        end
        M0: next_line = line_end;
        M1: begin
          if (line_end) begin
            dot_d = '0;
            if (ly_q == LastLy) begin
              ly_d          = '0;
              state_d       = M2;
              m2_start_d    = 1'b1;
              frame_start_d = 1'b1;
            end else begin
              ly_d = ly_q + 1'b1;
            end
          end
        end
        default: state_d = OFF;
      endcase

      if (next_line) begin
        dot_d = '0;
        ly_d  = ly_q + 1'b1;
        if (ly_q == LastVisLy) begin
          state_d      = M1;
          vblank_irq_d = 1'b1;
        end else begin
          state_d    = M2;
          m2_start_d = 1'b1;
        end
      end
    end

    mode_d = mode_enc(state_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= OFF;
      dot_q         <= '0;
      ly_q          <= '0;
      mode_q        <= MODE_HBLANK;
      m2_start_q    <= 1'b0;
      m3_start_q    <= 1'b0;
      vblank_irq_q  <= 1'b0;
      frame_start_q <= 1'b0;
      overrun_q     <= 1'b0;
      done_lat_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      dot_q         <= dot_d;
      ly_q          <= ly_d;
      mode_q        <= mode_d;
      m2_start_q    <= m2_start_d;
      m3_start_q    <= m3_start_d;
      vblank_irq_q  <= vblank_irq_d;
      frame_start_q <= frame_start_d;
      overrun_q     <= overrun_d;
      done_lat_q    <= done_lat_d;
    end
  end

  assign run_d    = (state_d != OFF);
  assign active_q = (state_q != OFF);

  ppu_stat_irq u_stat_irq (
    .clk          (clk),
    .rst          (rst),
    .run_i        (run_d),
    .active_i     (active_q),
    .ly_next_i    (ly_d),
    .lyc_i        (lyc_i),
    .stat_src_en_i(stat_src_en_i),
    .mode_i       (mode_q),
    .lyc_eq_o     (lyc_eq_o),
    .stat_irq_o   (stat_irq_o)
  );

  assign m2_start_o    = m2_start_q;
  assign m3_start_o    = m3_start_q;
  assign mode_o        = mode_q;
  assign ly_o          = ly_q;
  assign dot_o         = dot_q;
  assign vblank_irq_o  = vblank_irq_q;
  assign frame_start_o = frame_start_q;
  assign m3_overrun_o  = overrun_q;

endmodule

// File: tb/tb_ppu_timing_gen.sv
// Self-checking bench for ppu_timing_gen: position-based reference model plus directed spot checks.
module tb_ppu_timing_gen;

  localparam int LINE  = 456;
  localparam int VIS   = 144;
  localparam int TOT   = 154;
  localparam int OAM   = 80;
  localparam int MINM3 = 172;
  localparam int MAXM3 = 289;
  localparam int FRAME = LINE * TOT;

  logic       clk = 1'b0;
  logic       rst, lcd_en, m3_done;
  logic [7:0] lyc;
  logic [3:0] src;
  logic       m2_start_o, m3_start_o, lyc_eq_o, stat_irq_o, vblank_irq_o;
  logic       frame_start_o, m3_overrun_o;
  logic [1:0] mode_o;
  logic [7:0] ly_o;
  logic [8:0] dot_o;

  ppu_timing_gen dut (
    .clk          (clk),
    .rst          (rst),
    .lcd_en_i     (lcd_en),
    .lyc_i        (lyc),
    .stat_src_en_i(src),
    .m3_done_i    (m3_done),
    .m2_start_o   (m2_start_o),
    .m3_start_o   (m3_start_o),
    .mode_o       (mode_o),
    .ly_o         (ly_o),
    .dot_o        (dot_o),
    .lyc_eq_o     (lyc_eq_o),
    .stat_irq_o   (stat_irq_o),
    .vblank_irq_o (vblank_irq_o),
    .frame_start_o(frame_start_o),
    .m3_overrun_o (m3_overrun_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: LCD on/off, position t within the frame, planned m3_done dot per line.
  bit         on = 1'b0;
  int         t = 0;
  bit         ovr = 1'b0;
  int         done_dot[TOT];
  bit         sl_cur = 1'b0, slq = 1'b0;
  bit         first_run = 1'b0, rand_regs = 1'b0;
  int         cyc = 0;
  bit         e_m2, e_m3, e_eq, e_si, e_vi, e_fs;
  logic [1:0] e_mode = 2'd0;
  logic [7:0] e_ly;
  logic [8:0] e_dot;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Dot at which mode 0 begins for a line whose fetcher finishes at dot d (-1: never).
  function automatic int m3_end(int d);
    int e;
    if (d < 0) e = LINE;
    else e = (d + 1 > OAM + MINM3) ? d + 1 : OAM + MINM3;
`ifdef PPU_M3_TIMEOUT_EN
    if (d < 0 || d >= OAM + MAXM3) e = OAM + MAXM3;
`endif
    return e;
  endfunction

  function automatic bit overruns(int d);
`ifdef PPU_M3_TIMEOUT_EN
    return (d < 0) || (d >= OAM + MAXM3);
`else
    return d < 0;
`endif
  endfunction

  function automatic int plan_done(int l);
    int r;
    if (first_run) begin
      if (l == 0) return 252;
      if (l == 1) return 100;
      if (l == 2) return LINE - 1;
      if (l == 3) return -1;
      if (l == 6) return 200;
      if (l == 20) return -1;
    end
    r = int'($urandom_range(0, 9));
    if (r == 0) return -1;
    if (r == 1) return LINE - 1;
    if (r == 2) return OAM + MINM3 - 1;
    if (r < 6) return int'($urandom_range(OAM, OAM + MINM3 - 2));
    return int'($urandom_range(OAM + MINM3, LINE - 2));
  endfunction

  task automatic cycle();
    int  l, d;
    bit  fresh;
    logic [31:0] obs, exp;
    sl_cur = on && ((e_eq && src[3]) || (e_mode == 2'd2 && src[2]) ||
                    (e_mode == 2'd1 && src[1]) || (e_mode == 2'd0 && src[0]));
    @(posedge clk);
    #1;
    cyc++;
    fresh = 1'b0;
    if (rst) begin
      on = 1'b0; t = 0; ovr = 1'b0; e_si = 1'b0; slq = 1'b0;
    end else begin
      if (!lcd_en) begin
        on = 1'b0; t = 0; ovr = 1'b0;
      end else if (!on) begin
        on = 1'b1; t = 0; fresh = 1'b1;
      end else begin
        t = (t + 1) % FRAME;
      end
      e_si = on && sl_cur && !slq;
      slq  = sl_cur;
    end
    l = t / LINE;
    d = t % LINE;
    if (on) begin
      if (d == 0 && l < VIS) done_dot[l] = plan_done(l);
`ifdef PPU_M3_TIMEOUT_EN
      if (l < VIS && d == OAM + MAXM3 && overruns(done_dot[l])) ovr = 1'b1;
`else
      if (!fresh && d == 0 && l > 0 && l - 1 < VIS && overruns(done_dot[l - 1])) ovr = 1'b1;
`endif
    end
    e_mode = !on ? 2'd0 : (l >= VIS) ? 2'd1 : (d < OAM) ? 2'd2 :
             (d < m3_end(done_dot[l])) ? 2'd3 : 2'd0;
    e_m2  = on && d == 0 && l < VIS;
    e_m3  = on && d == OAM && l < VIS;
    e_fs  = on && t == 0;
    e_vi  = on && l == VIS && d == 0;
    e_ly  = on ? 8'(l) : 8'd0;
    e_dot = on ? 9'(d) : 9'd0;
    e_eq  = on && (l == int'(lyc));
    obs = {6'd0, m2_start_o, m3_start_o, mode_o, ly_o, dot_o, lyc_eq_o, stat_irq_o,
           vblank_irq_o, frame_start_o, m3_overrun_o};
    exp = {6'd0, e_m2, e_m3, e_mode, e_ly, e_dot, e_eq, e_si, e_vi, e_fs, ovr};
    chk($sformatf("outputs{m2,m3,mode,ly,dot,eq,stat,vbl,fs,ovr}@cyc%0d", cyc), obs, exp);
  endtask

  task automatic drive_auto();
    int l, d;
    l = t / LINE;
    d = t % LINE;
    m3_done = 1'b0;
    if (on && l < VIS && d == done_dot[l]) m3_done = 1'b1;
    // Stray pulses in mode 2 / mode 1 must be ignored.
    if (on && d == 40 && (l % 3) == 0) m3_done = 1'b1;
    if (rand_regs && on && d == 200 && $urandom_range(0, 3) == 0) begin
      src = 4'($urandom_range(0, 15));
      lyc = ($urandom_range(0, 1) == 1) ? 8'(l + 1) : 8'($urandom_range(0, 255));
    end
  endtask

  initial begin
    int target, fs_last, n_fs, n_vb;
    rst = 1'b1; lcd_en = 1'b0; m3_done = 1'b0; lyc = 8'd0; src = 4'd0;
    for (int i = 0; i < TOT; i++) done_dot[i] = -1;
    repeat (3) cycle();
    chk("reset_state", {mode_o, ly_o, dot_o, lyc_eq_o, m3_overrun_o, stat_irq_o}, 32'd0);
    lcd_en = 1'b1;
    repeat (2) cycle();
    chk("rst_over_lcd_en_mode", mode_o, 32'd0);

    rst = 1'b0; lyc = 8'd5; src = 4'b1000; first_run = 1'b1;
    target = 20 * LINE + 150;
    for (int i = 0; i < 20000 && !(on && t == target); i++) begin
      drive_auto();
      if (on && t == 6 * LINE + 300) begin
        lyc = 8'd7; src = 4'b1001;
      end
      cycle();
      if (t == 0 && frame_start_o) chk("first_m2_start", m2_start_o, 32'd1);
      if (t == 252) chk("l0_m3_at_252", mode_o, 32'd3);
      if (t == 253) chk("l0_m0_at_253", mode_o, 32'd0);
      if (t == LINE) chk("l1_m2_start", m2_start_o, 32'd1);
      if (t == LINE + 251) chk("l1_early_done_held", mode_o, 32'd3);
      if (t == LINE + 252) chk("l1_min_exit", mode_o, 32'd0);
      if (t == 3 * LINE) chk("done_at_line_end_no_ovr", m3_overrun_o, 32'd0);
      if (t == 4 * LINE) chk("no_done_ovr", m3_overrun_o, 32'd1);
      if (t == 5 * LINE) chk("lyc_irq_not_yet", stat_irq_o, 32'd0);
      if (t == 5 * LINE + 1) chk("lyc_irq_pulse", stat_irq_o, 32'd1);
      if (t == 5 * LINE + 2) chk("lyc_irq_single", stat_irq_o, 32'd0);
      if (t == 6 * LINE + 301) chk("enable_src_pulse", stat_irq_o, 32'd1);
      if (t == 7 * LINE + 1) chk("stat_blocking", stat_irq_o, 32'd0);
    end
    chk("reached_l20", 32'(t), 32'(target));
    chk("l20_in_m3", mode_o, 32'd3);

    lcd_en = 1'b0; m3_done = 1'b0;
    cycle();
    chk("off_outputs", {mode_o, ly_o, dot_o, stat_irq_o, vblank_irq_o, m3_start_o}, 32'd0);
    repeat (2) cycle();
    chk("off_held_no_m3_start", {m3_start_o, m3_overrun_o}, 32'd0);

    lcd_en = 1'b1; first_run = 1'b0; rand_regs = 1'b1;
    cycle();
    chk("reen_m2_start", m2_start_o, 32'd1);
    chk("reen_frame_start", frame_start_o, 32'd1);
    fs_last = cyc; n_fs = 0; n_vb = 0;
    for (int i = 0; i < FRAME + 2 * LINE; i++) begin
      drive_auto();
      cycle();
      if (vblank_irq_o) begin
        n_vb++;
        chk("vblank_delay", 32'(cyc - fs_last), 32'(VIS * LINE));
        chk("vblank_ly", ly_o, 32'(VIS));
        chk("vblank_mode", mode_o, 32'd1);
      end
      if (frame_start_o) begin
        n_fs++;
        chk("frame_period", 32'(cyc - fs_last), 32'(FRAME));
        fs_last = cyc;
      end
    end
    chk("frame_start_count", 32'(n_fs), 32'd1);
    chk("vblank_count", 32'(n_vb), 32'd1);

    rst = 1'b1; m3_done = 1'b0;
    cycle();
    chk("mid_rst", {mode_o, ly_o, dot_o, lyc_eq_o, m3_overrun_o}, 32'd0);
    rst = 1'b0;
    cycle();
    chk("post_rst_frame_start", frame_start_o, 32'd1);
    repeat (4) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
